hazard_ctrl: RTL and testbench

Parametrised hazard controller for the 5-stage pipelined core, replacing the forwarding-only unit. It does three things:
- Generates per-operand forwarding selects for NUM_SRC execute-stage source operands, with x0 masking and per-stage write gating.
- Detects load-use hazards and branch-taken flushes.
- Runs a counter FSM that holds a multi-cycle (mul/div) operation in Execute for MUL_LAT cycles.

It sits beside the pipeline registers and drives their stall/flush enables.

---
 rtl/hazard_pkg.sv | 17 +
 rtl/hazard_ctrl_fwd_sel.sv | 25 ++
 rtl/hazard_ctrl.sv | 111 +++++++++++
 tb/tb_hazard_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_W   = 2'b01,
    FWD_M   = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mul_state_t;

  localparam logic [1:0] RESULT_LOAD = 2'b01;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// One execute-stage forwarding channel: picks M, W or register file for a source operand.
module fwd_sel
  import hazard_pkg::*;
#(
  parameter int AW = 5
) (
  input  logic [AW-1:0] rs,
  input  logic [AW-1:0] rd_m,
  input  logic [AW-1:0] rd_w,
  input  logic [2:0]    regwrite_m,
  input  logic [2:0]    regwrite_w,
  output fwd_sel_t      fwd
);

  // The youngest producer (Memory) wins; x0 is hardwired zero and never forwarded.
  always_comb begin
    fwd = FWD_REG;
    if ((|regwrite_m) && (|rd_m) && (rd_m == rs)) begin
      fwd = FWD_M;
    end else if ((|regwrite_w) && (|rd_w) && (rd_w == rs)) begin
      fwd = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: operand forwarding, load-use/branch stall-flush control and
// a counter FSM that holds multi-cycle ops in Execute, plus a stall performance counter.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int AW      = 5,
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_SRC-1:0][AW-1:0]    RsD,
  input  logic [NUM_SRC-1:0][AW-1:0]    RsE,
  input  logic [AW-1:0]                 RdE,
  input  logic [AW-1:0]                 RdM,
  input  logic [AW-1:0]                 RdW,
  input  logic [2:0]                    RegWriteE,
  input  logic [2:0]                    RegWriteM,
  input  logic [2:0]                    RegWriteW,
  input  logic [1:0]                    ResultSrcE,
  input  logic                          PCSrcE,
  input  logic                          MulStartE,
  output logic [NUM_SRC-1:0][1:0]       ForwardE,
  output logic                          StallF,
  output logic                          StallD,
  output logic                          StallE,
  output logic                          FlushD,
  output logic                          FlushE,
  output logic                          FlushM,
  output logic                          MulDone,
  output logic                          MulBusy,
  output logic [CNT_W-1:0]              StallCount
);

  localparam int CW = $clog2(MUL_LAT);

  if (MUL_LAT < 2) begin : g_bad_mul_lat
    $error("hazard_ctrl: MUL_LAT must be >= 2");
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_fwd
    fwd_sel_t sel;
    fwd_sel #(.AW(AW)) u_fwd_sel (
      .rs         (RsE[i]),
      .rd_m       (RdM),
      .rd_w       (RdW),
      .regwrite_m (RegWriteM),
      .regwrite_w (RegWriteW),
      .fwd        (sel)
    );
    assign ForwardE[i] = sel;
  end

  logic lu;
  always_comb begin
    lu = 1'b0;
    if ((ResultSrcE == RESULT_LOAD) && (|RegWriteE) && (|RdE)) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (RdE == RsD[i]) lu = 1'b1;
      end
    end
  end

  mul_state_t      state;
  logic [CW-1:0]   cnt;
  logic            mstall;

  // cnt is loaded with MUL_LAT-2 so the final (cnt==0) BUSY cycle is the done cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (MulStartE) begin
            state <= BUSY;
            cnt   <= CW'(MUL_LAT - 2);
          end
        end
        BUSY: begin
          if (cnt != '0) cnt <= cnt - CW'(1);
          else           state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mstall  = ((state == IDLE) && MulStartE) || ((state == BUSY) && (cnt != '0));
  assign MulBusy = (state == BUSY);
  assign MulDone = (state == BUSY) && (cnt == '0);

  // A held multi-cycle op must never be flushed, so mstall masks every flush.
  assign StallE = mstall;
  assign FlushM = mstall;
  assign StallF = mstall | lu;
  assign StallD = mstall | lu;
  assign FlushE = ~mstall & (lu | PCSrcE);
  assign FlushD = ~mstall & PCSrcE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      StallCount <= '0;
    end else if (StallF && (StallCount != '1)) begin
      StallCount <= StallCount + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: vector table for combinational paths plus FSM/counter sequences.
module tb_hazard_ctrl;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0][4:0]   RsD, RsE;
  logic [4:0]        RdE, RdM, RdW;
  logic [2:0]        RegWriteE, RegWriteM, RegWriteW;
  logic [1:0]        ResultSrcE;
  logic              PCSrcE, MulStartE;

  logic [1:0][1:0]   ForwardE, ForwardE2;
  logic              StallF, StallD, StallE, FlushD, FlushE, FlushM, MulDone, MulBusy;
  logic              StallF2, StallD2, StallE2, FlushD2, FlushE2, FlushM2, MulDone2, MulBusy2;
  logic [31:0]       StallCount;
  logic [3:0]        StallCount2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n), .RsD(RsD), .RsE(RsE), .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .MulStartE(MulStartE),
    .ForwardE(ForwardE), .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .MulDone(MulDone),
    .MulBusy(MulBusy), .StallCount(StallCount)
  );

  hazard_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .RsD(RsD), .RsE(RsE), .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .MulStartE(MulStartE),
    .ForwardE(ForwardE2), .StallF(StallF2), .StallD(StallD2), .StallE(StallE2),
    .FlushD(FlushD2), .FlushE(FlushE2), .FlushM(FlushM2), .MulDone(MulDone2),
    .MulBusy(MulBusy2), .StallCount(StallCount2)
  );

  // {fwd1, fwd0, StallF, StallD, StallE, FlushD, FlushE, FlushM, MulDone, MulBusy}
  logic [11:0] obs;
  assign obs = {ForwardE, StallF, StallD, StallE, FlushD, FlushE, FlushM, MulDone, MulBusy};

  typedef struct {
    logic [4:0]  rsd0, rsd1, rse0, rse1, rde, rdm, rdw;
    logic [2:0]  rwe, rwm, rww;
    logic [1:0]  rsrc;
    logic        pc;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    RsD = '0; RsE = '0; RdE = '0; RdM = '0; RdW = '0;
    RegWriteE = '0; RegWriteM = '0; RegWriteW = '0;
    ResultSrcE = '0; PCSrcE = 1'b0; MulStartE = 1'b0;
  endtask

  task automatic set_load_use();
    RdE = 5'd7; ResultSrcE = 2'b01; RegWriteE = 3'd1; RsD[1] = 5'd7;
  endtask

  logic [31:0] cnt_before;

  initial begin
    //                rsd0 rsd1 rse0 rse1 rde rdm rdw rwe rwm rww rsrc pc  exp
    vecs[0]  = '{0, 0, 5, 0, 0, 5, 5, 0, 1, 1, 2'b00, 0, 12'b00_10_000000_00};
    vecs[1]  = '{0, 0, 5, 0, 0, 5, 5, 0, 0, 1, 2'b00, 0, 12'b00_01_000000_00};
    vecs[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2'b00, 0, 12'b00_00_000000_00};
    vecs[3]  = '{0, 0, 3, 4, 0, 4, 3, 0, 2, 4, 2'b00, 0, 12'b10_01_000000_00};
    vecs[4]  = '{0, 0, 0, 6, 0, 6, 6, 0, 0, 0, 2'b00, 0, 12'b00_00_000000_00};
    vecs[5]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 12'b00_00_000110_00};
    vecs[6]  = '{0, 7, 0, 0, 7, 0, 0, 1, 0, 0, 2'b01, 0, 12'b00_00_110010_00};
    vecs[7]  = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b01, 0, 12'b00_00_000000_00};
    vecs[8]  = '{0, 7, 0, 0, 7, 0, 0, 1, 0, 0, 2'b00, 0, 12'b00_00_000000_00};
    vecs[9]  = '{7, 0, 0, 0, 7, 0, 0, 0, 0, 0, 2'b01, 0, 12'b00_00_000000_00};
    vecs[10] = '{7, 0, 0, 0, 7, 0, 0, 4, 0, 0, 2'b01, 1, 12'b00_00_110110_00};
    vecs[11] = '{0, 7, 0, 0, 7, 0, 0, 1, 0, 0, 2'b10, 0, 12'b00_00_000000_00};

    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {20'd0, obs}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_outputs", {20'd0, obs}, 32'd0);
    check("idle_stallcount", StallCount, 32'd0);

    // Combinational vectors, FSM idle
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      clear_inputs();
      RsD[0] = vecs[i].rsd0; RsD[1] = vecs[i].rsd1;
      RsE[0] = vecs[i].rse0; RsE[1] = vecs[i].rse1;
      RdE = vecs[i].rde; RdM = vecs[i].rdm; RdW = vecs[i].rdw;
      RegWriteE = vecs[i].rwe; RegWriteM = vecs[i].rwm; RegWriteW = vecs[i].rww;
      ResultSrcE = vecs[i].rsrc; PCSrcE = vecs[i].pc;
      #2;
      check($sformatf("vec%0d", i), {20'd0, obs}, {20'd0, vecs[i].exp});
    end

    // Load-use: one stall cycle, then the load moves to M and forwards
    @(negedge clk);
    clear_inputs();
    set_load_use();
    RsE[1] = 5'd3;
    #2;
    cnt_before = StallCount;
    check("lu_stall", {29'd0, StallF, StallD, FlushE}, 32'b111);
    @(negedge clk);
    clear_inputs();
    RdM = 5'd7; RegWriteM = 3'd1; RsE[1] = 5'd7;
    #2;
    check("lu_released", {20'd0, obs}, {20'd0, 12'b10_00_000000_00});
    check("lu_count_inc", StallCount, cnt_before + 32'd1);

    // Multi-cycle op, MulStartE held 5 cycles (5th restarts back-to-back)
    @(negedge clk);
    clear_inputs();
    MulStartE = 1'b1;
    #2;
    check("mul_c1", {26'd0, StallF, StallE, FlushM, FlushE, MulDone, MulBusy}, 32'b111000);
    @(negedge clk);
    set_load_use();
    #2;
    check("mul_c2_lu", {26'd0, StallF, StallE, FlushM, FlushE, MulDone, MulBusy}, 32'b111001);
    @(negedge clk);
    clear_inputs();
    MulStartE = 1'b1;
    PCSrcE = 1'b1;
    #2;
    check("mul_c3_br", {25'd0, StallF, StallE, FlushM, FlushD, FlushE, MulDone, MulBusy}, 32'b1110001);
    @(negedge clk);
    PCSrcE = 1'b0;
    #2;
    check("mul_c4_done", {26'd0, StallF, StallE, FlushM, FlushE, MulDone, MulBusy}, 32'b000011);
    @(negedge clk);
    #2;
    check("mul_b2b_start", {26'd0, StallF, StallE, FlushM, FlushE, MulDone, MulBusy}, 32'b111000);
    @(negedge clk);
    MulStartE = 1'b0;
    #2;
    check("mul_b2b_busy", {26'd0, StallF, StallE, FlushM, FlushE, MulDone, MulBusy}, 32'b111001);

    // Asynchronous reset mid-BUSY
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_async", {29'd0, MulBusy, StallE, MulDone}, 32'd0);
    check("rst_count", StallCount, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    check("post_rst_idle", {20'd0, obs}, 32'd0);

    // Saturation of the 4-bit counter across 20 stalled cycles
    @(negedge clk);
    set_load_use();
    repeat (20) @(negedge clk);
    clear_inputs();
    #2;
    check("sat_cnt4", {28'd0, StallCount2}, 32'd15);
    check("cnt32_20", StallCount, 32'd20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
